fp_add_issue: RTL
=================

// Module: fp_add_issue
// PURPOSE
// Issue/retire stage wrapped around the combinational FP32 add/sub datapath.
// - Buffers operand requests from a valid/ready stream in a FIFO.
// - Drives the head request onto the adder's a/b/op inputs.
// - Resolves special operands the adder cannot handle (zero, denormal, inf, NaN, exact cancel).
// - Registers each result with its tag into an output stage that accepts back-pressure.
// PARAMETERS
// DEPTH   4   request FIFO entries (power of 2, >=2)
// TAG_W   4   width of the request tag carried alongside each operation
// PORTS
// clk        in   1      clock, all state on rising edge
// rst        in   1      asynchronous active-high reset
// in_valid   in   1      request valid
// in_ready   out  1      FIFO can accept a request
// in_op      in   1      0 = a+b, 1 = a-b
// in_a       in   32     FP32 operand a
// in_b       in   32     FP32 operand b
// in_tag     in   TAG_W  request tag
// add_a      out  32     head operand a to adder (0 when FIFO empty)
// add_b      out  32     head operand b to adder (0 when FIFO empty)
// add_op     out  1      head op to adder (0 when FIFO empty)
// add_c      in   32     combinational adder result for add_a/add_b/add_op
// out_valid  out  1      result register holds a result
// out_ready  in   1      consumer accepts result
// out_c      out  32     FP32 result
// out_tag    out  TAG_W  tag of result
// out_flags  out  3      [0] bypass (special path), [1] NaN, [2] infinity
// ops_cnt    out  16     retired results (out_valid & out_ready), wraps at 2^16
// BEHAVIOUR
// - Reset, async: FIFO pointers and count = 0; result register empty.
//   out_valid=0, out_c=0, out_tag=0, out_flags=0, ops_cnt=0, in_ready=1.
//   Reset mid-operation discards every queued request and the held result.
// - FIFO
//   - in_ready = (count != DEPTH).
//   - Push on in_valid & in_ready; pop when the head is captured.
//   - Simultaneous push and pop: count unchanged. Pointers wrap modulo DEPTH.
// - Capture
//   - Head captured when FIFO non-empty AND (!out_valid OR out_ready).
//   - Result register then loads: out_c/out_tag/out_flags; out_valid=1.
//   - If out_valid & out_ready and nothing is captured: out_valid=0 next edge.
//   - Minimum latency: accept at edge k -> out_valid high after edge k+1.
//   - Sustained rate: 1 result/cycle when out_ready=1.
//   - out_* held stable while out_valid & !out_ready.
// - Special-case resolution on head (combinational; bE = b[31]^op is the effective b sign)
//   - exp==0 is treated as zero; denormals are flushed.
//   - exp==255 & mant!=0 is NaN. exp==255 & mant==0 is inf.
//   - Priority, first match wins:
//     1. Either operand NaN -> 32'h7FC00000, flags 3'b011.
//     2. Both inf, a[31]!=bE -> 32'h7FC00000, flags 3'b011.
//     3. a inf -> {a[31],31'h7F800000}, flags 3'b101.
//        b inf -> {bE,31'h7F800000}, flags 3'b101.
//     4. Both zero -> {a[31]&bE,31'b0}, flags 3'b001.
//     5. a zero -> {bE,b[30:0]}; b zero -> a; flags 3'b001.
//     6. a[30:0]==b[30:0] & a[31]!=bE -> 32'h00000000, flags 3'b001.
//     7. Otherwise -> add_c, flags 3'b000.
//   - add_c is ignored for bypassed entries; add_* still show the head.
// - ops_cnt increments on every out_valid & out_ready, wrapping 16'hFFFF->0.
// TESTING
// - Reset, then in 1.0+2.0 (3F800000,40000000,op0,tag 3), out_ready=1
//   -> out_valid 2 cycles after accept; out_c from add_c=40400000; tag 3; flags 000.
// - out_ready=0, push 5 requests back-to-back
//   -> in_ready low after DEPTH+1=5 accepted (4 FIFO + 1 output reg).
//   -> Raise out_ready: 5 results in order, 1/cycle; ops_cnt=5.
// - a=7F800000, b=7F800000, op=1 -> out_c=7FC00000, flags 011.
//   a=7FC00001, any b -> 7FC00000.
// - a=00000000, b=C0000000, op=1 -> out_c=40000000, flags 001.
//   a=80000000, b=00000000, op=1 -> 80000000.
// - a=3F800000, b=3F800000, op=1 -> out_c=00000000, flags 001; add_c ignored.
// - Assert rst with 3 queued and out_valid=1
//   -> out_valid=0, in_ready=1, ops_cnt=0 immediately; no stale results after release.

Source files
------------

// File: rtl/fp_add_issue.sv
// Issue/retire stage around a combinational FP32 add/sub datapath.
// Requests queue in a small FIFO; the head drives the adder, special
// operands are resolved locally, and results land in a back-pressured
// output register together with their tag and classification flags.
module fp_add_issue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    output logic             add_op,
    input  logic [31:0]      add_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_c,
    output logic [TAG_W-1:0] out_tag,
    output logic [2:0]       out_flags,
    output logic [15:0]      ops_cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      memA   [DEPTH];
    logic [31:0]      memB   [DEPTH];
    logic             memOp  [DEPTH];
    logic [TAG_W-1:0] memTag [DEPTH];

    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] cnt;

    logic             fifoEmpty;
    logic             push;
    logic             capture;
    logic             retire;

    logic [31:0]      headA;
    logic [31:0]      headB;
    logic             headOp;
    logic [TAG_W-1:0] headTag;

    logic             bEff;
    logic             aNan, bNan, aInf, bInf, aZero, bZero;
    logic [31:0]      resC;
    logic [2:0]       resFlags;

    assign fifoEmpty = (cnt == '0);
    assign in_ready  = (cnt != CNT_W'(DEPTH));
    assign push      = in_valid & in_ready;
    assign capture   = !fifoEmpty & (!out_valid | out_ready);
    assign retire    = out_valid & out_ready;

    // Head of queue; forced to zero when nothing is queued
    assign headA   = fifoEmpty ? 32'h0 : memA[rdPtr];
    assign headB   = fifoEmpty ? 32'h0 : memB[rdPtr];
    assign headOp  = fifoEmpty ? 1'b0  : memOp[rdPtr];
    assign headTag = fifoEmpty ? '0    : memTag[rdPtr];

    assign add_a  = headA;
    assign add_b  = headB;
    assign add_op = headOp;

    // Operand classification; exponent 0 is zero (denormals flushed)
    assign bEff  = headB[31] ^ headOp;
    assign aNan  = (headA[30:23] == 8'hFF) && (headA[22:0] != 23'h0);
    assign bNan  = (headB[30:23] == 8'hFF) && (headB[22:0] != 23'h0);
    assign aInf  = (headA[30:23] == 8'hFF) && (headA[22:0] == 23'h0);
    assign bInf  = (headB[30:23] == 8'hFF) && (headB[22:0] == 23'h0);
    assign aZero = (headA[30:23] == 8'h00);
    assign bZero = (headB[30:23] == 8'h00);

    // FIFO storage write; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (push) begin
            memA[wrPtr]   <= in_a;
            memB[wrPtr]   <= in_b;
            memOp[wrPtr]  <= in_op;
            memTag[wrPtr] <= in_tag;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
        end else begin
            if (push)    wrPtr <= wrPtr + PTR_W'(1);
            if (capture) rdPtr <= rdPtr + PTR_W'(1);
            case ({push, capture})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Special-operand resolution, first match wins; otherwise take the adder
    always_comb begin
        resC     = add_c;
        resFlags = 3'b000;
        if (aNan || bNan) begin
            resC     = 32'h7FC0_0000;
            resFlags = 3'b011;
        end else if (aInf && bInf && (headA[31] != bEff)) begin
            resC     = 32'h7FC0_0000;
            resFlags = 3'b011;
        end else if (aInf) begin
            resC     = {headA[31], 31'h7F80_0000};
            resFlags = 3'b101;
        end else if (bInf) begin
            resC     = {bEff, 31'h7F80_0000};
            resFlags = 3'b101;
        end else if (aZero && bZero) begin
            resC     = {headA[31] & bEff, 31'h0};
            resFlags = 3'b001;
        end else if (aZero) begin
            resC     = {bEff, headB[30:0]};
            resFlags = 3'b001;
        end else if (bZero) begin
            resC     = headA;
            resFlags = 3'b001;
        end else if ((headA[30:0] == headB[30:0]) && (headA[31] != bEff)) begin
            resC     = 32'h0;
            resFlags = 3'b001;
        end
    end

    // Result register with back-pressure, plus retire counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_c     <= 32'h0;
            out_tag   <= '0;
            out_flags <= 3'b000;
            ops_cnt   <= 16'h0;
        end else begin
            if (capture) begin
                out_valid <= 1'b1;
                out_c     <= resC;
                out_tag   <= headTag;
                out_flags <= resFlags;
            end else if (retire) begin
                out_valid <= 1'b0;
            end
            if (retire) ops_cnt <= ops_cnt + 16'd1;
        end
    end

endmodule
